// File: rtl/serial_adder_unit_pkg.sv
// Shared constants for the bit-serial adder/subtractor family.
// State encoding and default operand width.
package serial_adder_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_gatelevel.sv
// One-bit full adder from gate primitives.
// Same cell structure as the serial subtractor uses.
module full_adder_gatelevel (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic t;

    xor x_p  (p, a, b);
    xor x_s  (s, p, c);
    and a_g  (g, a, b);
    and a_t  (t, p, c);
    or  o_co (co, g, t);

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// start/busy/done handshake; sum/cout hold the last completed result.
module serial_adder_unit
    import serial_adder_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    full_adder_gatelevel u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == LAST);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial shift and result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                ADD: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= {fa_s, res_sh[WIDTH-1:1]};
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit (WIDTH=8 and WIDTH=4 instances).
// Stimulus pushes expected results; monitors pop and compare on done.
module tb_serial_adder_unit;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;
    logic       done8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic [3:0] sum4;
    logic       cout4;
    logic       busy4;
    logic       done4;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q4[$];

    serial_adder_unit #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .cout  (cout8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_adder_unit #(.WIDTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .sum   (sum4),
        .cout  (cout4),
        .busy  (busy4),
        .done  (done4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected_done got=1 exp=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_result", int'({cout8, sum8}), e.res);
                check("w8_latency", cyc, e.cyc);
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w4_unexpected_done got=1 exp=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("w4_result", int'({cout4, sum4}), e.res);
                check("w4_latency", cyc, e.cyc);
            end
        end
    end

    // One 8-bit add with a hand-computed {cout,sum}, then wait for idle
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input int exp);
        @(negedge clk);
        a8 = av;
        b8 = bv;
        cin8 = cv;
        start8 = 1'b1;
        q8.push_back('{exp, cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20 && busy8; i++) @(negedge clk);
        check("w8_idle_after_run", int'(busy8), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int bad;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sum", int'(sum8), 0);
        check("rst_cout", int'(cout8), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);

        // Basic add with busy length and sum-hold during ADD
        @(negedge clk);
        a8 = 8'h3C;
        b8 = 8'h5A;
        cin8 = 1'b0;
        start8 = 1'b1;
        q8.push_back('{9'h096, cyc + 1 + 8});
        n = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) n++;
            if (busy8 && !done8 && sum8 != 8'h00) bad++;
        end
        check("basic_busy_cycles", n, 9);
        check("basic_sum_hold", bad, 0);

        // Carry ripple
        run8(8'hFF, 8'h01, 1'b0, 9'h100);
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Start while busy is dropped; start right after DONE accepted
        @(negedge clk);
        c = cyc;
        a8 = 8'h10;
        b8 = 8'h20;
        cin8 = 1'b0;
        start8 = 1'b1;
        q8.push_back('{9'h030, c + 9});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA;
        b8 = 8'h55;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_drop_done_cycle", int'(done8), 1);
        a8 = 8'hAA;
        b8 = 8'h55;
        start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h01;
        b8 = 8'h01;
        q8.push_back('{9'h002, cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20 && busy8; i++) @(negedge clk);
        check("busy_drop_idle", int'(busy8), 0);

        // Reset mid-operation
        @(negedge clk);
        a8 = 8'h7F;
        b8 = 8'h01;
        cin8 = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sum", int'(sum8), 0);
        check("midrst_cout", int'(cout8), 0);
        check("midrst_busy", int'(busy8), 0);
        check("midrst_done", int'(done8), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_done_pending", int'(busy8), 0);
        run8(8'h01, 8'h02, 1'b0, 9'h003);

        // Exhaustive 4-bit sweep, back-to-back starts
        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    @(negedge clk);
                    a4 = 4'(ai);
                    b4 = 4'(bi);
                    cin4 = 1'(ci);
                    start4 = 1'b1;
                    q4.push_back('{ai + bi + ci, cyc + 1 + 4});
                    @(negedge clk);
                    start4 = 1'b0;
                    repeat (4) @(negedge clk);
                end
            end
        end

        // Drain with a bound
        for (int i = 0; i < 50 && (q8.size() != 0 || q4.size() != 0); i++)
            @(negedge clk);
        check("drain_q8", q8.size(), 0);
        check("drain_q4", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
- Bit-serial WIDTH-bit adder built around one gate-level full-adder cell and a carry flip-flop.
- Adds one bit per clock, LSB first.
- Uses a start/busy/done handshake.
- Serves as the addition counterpart of the team's gate-level subtractor, for area-constrained datapaths where a ripple array is too large.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- sum  output  WIDTH  registered result; holds the last completed result.
- cout  output  1  registered carry-out of the last completed result.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse marking that sum/cout were just updated.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, sum=0, cout=0, busy=0, done=0.
  - internal shift registers, carry flop and bit counter cleared.
  - Reset mid-operation aborts the addition; no done pulse is produced; sum/cout read 0.
- States: IDLE, ADD, DONE. busy = (state != IDLE).
- IDLE:
  - With start=1 at a rising edge: load a_sh=a, b_sh=b, carry=cin, cnt=0, res_sh=0; next state ADD.
  - With start=0: remain in IDLE; all outputs hold.
- ADD, each cycle:
  - Full-adder cell computes s = a_sh[0]^b_sh[0]^carry and co = majority(a_sh[0], b_sh[0], carry).
  - res_sh <= {s, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; carry <= co; cnt <= cnt+1.
  - When cnt == WIDTH-1, on that same edge:
    - sum <= {s, res_sh[WIDTH-1:1]}.
    - cout <= co.
    - next state DONE.
- DONE:
  - done=1 for exactly this one cycle; next state IDLE unconditionally.
  - start is ignored in DONE.
- Latency: if start is accepted at edge E0, then:
  - ADD occupies WIDTH cycles.
  - sum/cout update at edge E0+WIDTH.
  - done is high between edges E0+WIDTH and E0+WIDTH+1.
  - The earliest next accepted start is edge E0+WIDTH+2.
- Start arriving while busy=1 is dropped, not queued. Operand changes while busy have no effect.
- sum and cout do not change during ADD. They keep the previous result until the final ADD edge.
- Arithmetic:
  - {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
  - Signed interpretation is left to the consumer.
- Counter width: $clog2(WIDTH). Terminal compare is against WIDTH-1, so there is no wrap-around hazard.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - the default WIDTH constant, so subtractor and adder wrappers agree.
- One sub-module: full_adder_gatelevel (a, b, c -> s, co). Built from gate primitives only: two xor, two and, one or, mirroring the subtractor cell. Instantiated once.
- FSM, shift registers, counter and output registers live in serial_adder_unit.

Test Plan:
- Reset then idle, WIDTH=8: hold rst_n=0 for 3 cycles, release, keep start=0 for 5 cycles -> sum=0x00, cout=0, busy=0, done never pulses.
- Basic add: a=0x3C, b=0x5A, cin=0, start for one cycle -> busy high for 9 cycles, done pulses once at edge E0+8, sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: start a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 at E0+3 and again during the DONE cycle -> both extra starts ignored, single done, sum=0x30, cout=0. A start at E0+10 is accepted.
- Reset mid-operation: start a=0x7F, b=0x01, assert rst_n=0 asynchronously between edges E0+4 and E0+5 -> all outputs 0 immediately, no done. A new add a=0x01, b=0x02 after release yields sum=0x03.
- Exhaustive with WIDTH=4: all a, b, cin combinations (512 runs) -> {cout, sum} matches a+b+cin every run, and the latency from accepted start to done is exactly 4 edges.
